add_sub_stream_tx: RTL and testbench
====================================

// Module: add_sub_stream_tx
// PURPOSE
//  Producer-side packetizer for the add_sub valid/ack stream. Takes a length command, pulls that
//  many words from an unframed source stream, and drives them downstream with a last marker
//  through a registered output stage. Sits upstream of the regslice feeding the AXI-Stream port.
//  Pulses done when the final word is accepted downstream.
// PARAMETERS
//  DataWidth  32  payload width in bits
//  LenWidth   16  width of packet-length command; max packet = 2**LenWidth-1 words
// PORTS
//  ap_clk    in   1          clock; all logic on rising edge
//  ap_rst    in   1          asynchronous, active-high reset
//  cmd_len   in   LenWidth   packet length in words; 0 = empty packet
//  cmd_vld   in   1          command valid
//  cmd_ack   out  1          command accepted when cmd_vld & cmd_ack
//  src_data  in   DataWidth  source word
//  src_vld   in   1          source valid
//  src_ack   out  1          source word consumed when src_vld & src_ack
//  m_data    out  DataWidth  output word (registered)
//  m_last    out  1          marks final word of packet (registered)
//  m_vld     out  1          output valid (registered)
//  m_ack     in   1          downstream accept; transfer when m_vld & m_ack
//  done      out  1          one-cycle pulse: packet complete
//  busy      out  1          high when state != IDLE
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): state=IDLE, remaining=0, m_vld=0, m_last=0,
//    m_data=0, done=0, busy=0. Reset mid-packet drops the partial packet with no done pulse.
//  - FSM states IDLE, XFER, DRAIN.
//    IDLE: cmd_ack=1, src_ack=0. On cmd handshake: cmd_len==0 -> done=1 next cycle, stay IDLE;
//          else remaining<=cmd_len, go XFER.
//    XFER: src_ack = ~m_vld | m_ack (combinational). On src handshake: m_data<=src_data,
//          m_vld<=1, m_last<=(remaining==1), remaining<=remaining-1; if remaining==1 go DRAIN.
//          If m_vld & m_ack and no src handshake: m_vld<=0.
//    DRAIN: src_ack=0, cmd_ack=0. On m_vld & m_ack & m_last: m_vld<=0, m_last<=0, done<=1,
//          go IDLE.
//  - cmd_ack = (state==IDLE); no command accepted until the previous last word is accepted.
//  - Latency src handshake -> m_vld: 1 cycle. Throughput: 1 word/cycle with m_ack held high.
//  - done asserts exactly 1 cycle after the last-word handshake (or the zero-length cmd
//    handshake); it is low in every other cycle.
//  - Output stability: while m_vld & ~m_ack, m_data/m_last/m_vld hold; src_ack=0.
//  - Simultaneous m_ack and src_vld in XFER: old word leaves and new word loads in the same
//    edge, with no bubble.
//  - remaining is LenWidth bits; cmd_len=2**LenWidth-1 is legal; m_last only on the final word.
//  - src_vld is ignored outside XFER; no word is ever dropped or duplicated.
// STRUCTURE
//  - Single flat module. State encodings (IDLE=2'd0, XFER=2'd1, DRAIN=2'd2) are localparams in the
//    shared add_sub stream defines header used by the regslice/stream blocks.
//  - No sub-module: the output register is inline. A regslice instance downstream provides the
//    skid/timing break.
// TESTING
//  1. cmd_len=4, src words 1,2,3,4 back-to-back, m_ack=1 -> m_data 1,2,3,4 on 4 consecutive
//     cycles, m_last only with 4, done 1 cycle after the 4th handshake.
//  2. cmd_len=4, m_ack low 3 cycles while m_data=2 -> m_data holds 2, src_ack=0 throughout;
//     output sequence 1,2,3,4 with no loss or duplicate.
//  3. cmd_len=0 -> m_vld never asserts, done pulse 1 cycle after cmd handshake, cmd_ack stays 1.
//  4. cmd_len=1 followed immediately by cmd_len=2 -> first packet is a single word with m_last=1;
//     cmd_ack low until that word is accepted; second packet is correct; two done pulses.
//  5. ap_rst asserted after 2 of 5 words -> m_vld=0 and busy=0 immediately, no done; a new
//     cmd_len=3 then completes normally.
//  6. LenWidth=4, cmd_len=15 with random src_vld/m_ack gaps -> exactly 15 words in order,
//     m_last only on the 15th.

Source files
------------

// File: rtl/add_sub_stream_tx_pkg.sv
// Shared definitions for the add_sub valid/ack stream blocks.
// State encodings are kept as plain constants so legacy stream blocks decode them unchanged.
package add_sub_stream_tx_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] XFER  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int unsigned StateWidth = 2;

endpackage

// File: rtl/add_sub_stream_tx.sv
// Producer-side packetizer: accepts a length command, pulls that many source words and
// presents them through a registered valid/ack output stage, tagging the final word with m_last.
module add_sub_stream_tx
    import add_sub_stream_tx_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int LenWidth  = 16
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [LenWidth-1:0]  cmd_len,
    input  logic                 cmd_vld,
    output logic                 cmd_ack,
    input  logic [DataWidth-1:0] src_data,
    input  logic                 src_vld,
    output logic                 src_ack,
    output logic [DataWidth-1:0] m_data,
    output logic                 m_last,
    output logic                 m_vld,
    input  logic                 m_ack,
    output logic                 done,
    output logic                 busy
);

    logic [StateWidth-1:0] state;
    logic [LenWidth-1:0]   remaining;
    logic                  cmd_hs;
    logic                  src_hs;
    logic                  m_hs;
    logic                  one_left;

    // The output register can accept a new word when empty or when its word leaves this edge.
    always_comb begin
        cmd_ack  = (state == IDLE);
        src_ack  = (state == XFER) & (~m_vld | m_ack);
        busy     = (state != IDLE);
        cmd_hs   = cmd_vld & cmd_ack;
        src_hs   = src_vld & src_ack;
        m_hs     = m_vld & m_ack;
        one_left = (remaining == LenWidth'(1));
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state     <= IDLE;
            remaining <= '0;
            m_data    <= '0;
            m_last    <= 1'b0;
            m_vld     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= cmd_len;
                            state     <= XFER;
                        end
                    end
                end
                XFER: begin
                    if (src_hs) begin
                        m_data    <= src_data;
                        m_vld     <= 1'b1;
                        m_last    <= one_left;
                        remaining <= remaining - LenWidth'(1);
                        if (one_left) begin
                            state <= DRAIN;
                        end
                    end else if (m_hs) begin
                        m_vld <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (m_hs & m_last) begin
                        m_vld  <= 1'b0;
                        m_last <= 1'b0;
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_sub_stream_tx.sv
// Self-checking bench for add_sub_stream_tx: table-driven packets, hand-written corner
// sequences and randomized traffic, all checked against a packet-level scoreboard.
module tb_add_sub_stream_tx;

    localparam int DW = 32;
    localparam int LW = 4;

    logic          ap_clk = 1'b0;
    logic          ap_rst;
    logic [LW-1:0] cmd_len;
    logic          cmd_vld;
    logic          cmd_ack;
    logic [DW-1:0] src_data;
    logic          src_vld;
    logic          src_ack;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          m_vld;
    logic          m_ack;
    logic          done;
    logic          busy;

    add_sub_stream_tx #(.DataWidth(DW), .LenWidth(LW)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .cmd_len(cmd_len), .cmd_vld(cmd_vld), .cmd_ack(cmd_ack),
        .src_data(src_data), .src_vld(src_vld), .src_ack(src_ack),
        .m_data(m_data), .m_last(m_last), .m_vld(m_vld), .m_ack(m_ack),
        .done(done), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    int checks = 0;
    int errors = 0;

    // stimulus requested for the next cycle
    logic          drv_cmd_vld = 1'b0;
    logic [LW-1:0] drv_cmd_len = '0;
    logic          drv_src_vld = 1'b0;
    logic [DW-1:0] drv_src_data = '0;
    logic          drv_m_ack = 1'b0;
    bit            use_count = 1'b0;
    logic [DW-1:0] next_word = '0;

    // packet-level reference model
    int unsigned   pkt_len = 0;
    int unsigned   consumed = 0;
    int unsigned   delivered = 0;
    bit            in_pkt = 1'b0;
    bit            done_exp = 1'b0;
    logic [DW-1:0] exp_q[$];
    int unsigned   words_seen = 0;
    int unsigned   dones_seen = 0;
    bit            hold_valid = 1'b0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;
    bit            ev_cmd = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        if (use_count) begin
            w = next_word;
            next_word = next_word + 1;
        end else begin
            w = $urandom;
        end
        return w;
    endfunction

    // One clock: drive inputs after the falling edge, then check and account for the
    // handshakes that the next rising edge will perform.
    task automatic step();
        logic [DW-1:0] exp_word;
        @(negedge ap_clk);
        cmd_vld  = drv_cmd_vld;
        cmd_len  = drv_cmd_len;
        src_vld  = drv_src_vld;
        src_data = drv_src_data;
        m_ack    = drv_m_ack;
        #1;
        chk("cmd_ack", cmd_ack, !in_pkt);
        chk("busy", busy, in_pkt);
        chk("done", done, done_exp);
        if (done) dones_seen++;
        chk("m_vld", m_vld, in_pkt && consumed > delivered);
        chk("src_ack", src_ack, in_pkt && consumed < pkt_len && (!m_vld || m_ack));
        if (hold_valid) begin
            chk("hold_data", m_data, hold_data);
            chk("hold_last", m_last, hold_last);
        end
        done_exp = 1'b0;
        ev_cmd   = 1'b0;
        if (m_vld && m_ack) begin
            exp_word = (exp_q.size() != 0) ? exp_q.pop_front() : ~m_data;
            chk("m_data", m_data, exp_word);
            delivered++;
            chk("m_last", m_last, delivered == pkt_len);
            words_seen++;
            if (in_pkt && delivered == pkt_len) begin
                in_pkt   = 1'b0;
                done_exp = 1'b1;
            end
        end
        hold_valid = m_vld && !m_ack;
        hold_data  = m_data;
        hold_last  = m_last;
        if (src_vld && src_ack) begin
            exp_q.push_back(src_data);
            consumed++;
            drv_src_data = gen_word();
        end
        if (cmd_vld && cmd_ack) begin
            ev_cmd = 1'b1;
            if (cmd_len == '0) begin
                done_exp = 1'b1;
            end else begin
                in_pkt    = 1'b1;
                pkt_len   = cmd_len;
                consumed  = 0;
                delivered = 0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge ap_clk);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("rst_m_vld", m_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_m_data", m_data, '0);
        chk("rst_cmd_ack", cmd_ack, 1'b1);
        drv_cmd_vld = 1'b0;
        drv_src_vld = 1'b0;
        drv_m_ack   = 1'b0;
        cmd_vld = 1'b0; src_vld = 1'b0; m_ack = 1'b0;
        in_pkt = 1'b0; done_exp = 1'b0; hold_valid = 1'b0;
        pkt_len = 0; consumed = 0; delivered = 0;
        exp_q.delete();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic timeout(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting on DUT, got no completion expected completion", nm);
        apply_reset();
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(99) < p;
    endfunction

    // Issues one command, streams it to completion and checks the done cycle.
    task automatic run_pkt(input int len, input int sp, input int ap, output int cycles);
        int n;
        cycles = -1;
        drv_cmd_vld = 1'b1;
        drv_cmd_len = LW'(len);
        n = 0;
        do begin
            drv_src_vld = pct(sp);
            drv_m_ack   = pct(ap);
            step();
            n++;
        end while (!ev_cmd && n < 200);
        drv_cmd_vld = 1'b0;
        if (!ev_cmd) begin
            timeout("cmd_wait");
            return;
        end
        n = 0;
        while (!done_exp && n < 600) begin
            drv_src_vld = pct(sp);
            drv_m_ack   = pct(ap);
            step();
            n++;
        end
        if (!done_exp) begin
            timeout("pkt_wait");
            return;
        end
        cycles = n;
        drv_src_vld = 1'b0;
        step();
    endtask

    typedef struct {
        int len;
        int src_pct;
        int ack_pct;
        int exp_words;
        int exp_dones;
        int exp_cycles;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int w0, d0, cyc, n;
        ap_rst = 1'b1;
        cmd_vld = 1'b0; cmd_len = '0; src_vld = 1'b0; src_data = '0; m_ack = 1'b0;
        #2;
        chk("init_m_vld", m_vld, 1'b0);
        chk("init_busy", busy, 1'b0);
        chk("init_done", done, 1'b0);
        chk("init_m_data", m_data, '0);
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        // full-throughput packets finish len+1 cycles after the command edge
        vecs.push_back('{4,  100, 100, 4,  1, 5});
        vecs.push_back('{0,  100, 100, 0,  1, 0});
        vecs.push_back('{1,  100, 100, 1,  1, 2});
        vecs.push_back('{15, 100, 100, 15, 1, 16});
        vecs.push_back('{15, 60,  50,  15, 1, -1});
        vecs.push_back('{7,  30,  80,  7,  1, -1});
        vecs.push_back('{15, 90,  20,  15, 1, -1});
        vecs.push_back('{3,  50,  50,  3,  1, -1});

        use_count = 1'b1;
        next_word = 1;
        drv_src_data = gen_word();
        foreach (vecs[i]) begin
            w0 = words_seen; d0 = dones_seen;
            run_pkt(vecs[i].len, vecs[i].src_pct, vecs[i].ack_pct, cyc);
            chk($sformatf("vec%0d_words", i), words_seen - w0, vecs[i].exp_words);
            chk($sformatf("vec%0d_dones", i), dones_seen - d0, vecs[i].exp_dones);
            if (vecs[i].exp_cycles >= 0)
                chk($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            step();
        end

        // stall with word 2 on the output for three cycles
        next_word = 1;
        drv_src_data = gen_word();
        w0 = words_seen;
        drv_cmd_vld = 1'b1; drv_cmd_len = 4; drv_src_vld = 1'b1; drv_m_ack = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ev_cmd && n < 20);
        drv_cmd_vld = 1'b0;
        step();
        step();
        drv_m_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_data", m_data, 2);
            chk("stall_src_ack", src_ack, 1'b0);
        end
        drv_m_ack = 1'b1;
        n = 0;
        while (!done_exp && n < 50) begin step(); n++; end
        if (!done_exp) timeout("stall_pkt");
        else step();
        chk("stall_words", words_seen - w0, 4);

        // back-to-back commands: 1 word then 2 words
        w0 = words_seen; d0 = dones_seen;
        drv_cmd_vld = 1'b1; drv_cmd_len = 1; drv_src_vld = 1'b1; drv_m_ack = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ev_cmd && n < 20);
        drv_cmd_len = 2;
        n = 0;
        do begin step(); n++; end while (!ev_cmd && n < 20);
        chk("b2b_second_cmd", ev_cmd, 1'b1);
        drv_cmd_vld = 1'b0;
        n = 0;
        while (!done_exp && n < 50) begin step(); n++; end
        if (!done_exp) timeout("b2b_pkt");
        else step();
        chk("b2b_words", words_seen - w0, 3);
        chk("b2b_dones", dones_seen - d0, 2);

        // reset after two of five words
        d0 = dones_seen;
        drv_cmd_vld = 1'b1; drv_cmd_len = 5; drv_src_vld = 1'b1; drv_m_ack = 1'b1;
        n = 0;
        do begin step(); n++; end while (!ev_cmd && n < 20);
        drv_cmd_vld = 1'b0;
        n = 0;
        while (delivered < 2 && n < 50) begin step(); n++; end
        apply_reset();
        for (int k = 0; k < 3; k++) step();
        chk("rst_no_done", dones_seen - d0, 0);
        w0 = words_seen;
        run_pkt(3, 100, 100, cyc);
        chk("post_rst_words", words_seen - w0, 3);
        chk("post_rst_cycles", cyc, 4);

        // randomized traffic with random data
        use_count = 1'b0;
        drv_src_data = gen_word();
        for (int p = 0; p < 20; p++) begin
            int len;
            len = $urandom_range(15);
            w0 = words_seen; d0 = dones_seen;
            run_pkt(len, $urandom_range(20, 100), $urandom_range(20, 100), cyc);
            chk($sformatf("rnd%0d_words", p), words_seen - w0, len);
            chk($sformatf("rnd%0d_dones", p), dones_seen - d0, 1);
            if ($urandom_range(1)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1);
    end

endmodule
